// File: rtl/pixel_stream_to_fixed_pkg.sv
// Shared types and elaboration-time helpers for the pixel -> fixed-point stream.
package pixel_stream_to_fixed_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_UNIT   = 2'd1,
        MODE_CENTRE = 2'd2
    } mode_e;

    // Output word width: integer bits (sign included) plus fraction bits.
    function automatic int unsigned out_w(input int unsigned int_bits, input int unsigned frac_bits);
        return int_bits + frac_bits;
    endfunction

    // The reserved encoding falls back to SHIFT.
    function automatic mode_e mode_decode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_UNIT;
            2'd2:    return MODE_CENTRE;
            default: return MODE_SHIFT;
        endcase
    endfunction

    // K = round(2^(frac+16) / (2^in_w - 1)), so that (max*K + 2^15) >> 16 == 1.0.
    function automatic longint unsigned unit_k(input int unsigned in_w, input int unsigned frac_bits);
        longint unsigned num;
        longint unsigned den;
        num = 64'd1 << (frac_bits + 16);
        den = (64'd1 << in_w) - 64'd1;
        return (num + den / 64'd2) / den;
    endfunction

    // Clip a signed value to the range of a w-bit two's complement word.
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/pixel_stream_to_fixed_if.sv
// Valid/ready stream bundle: pixel input side and fixed-point output side.
interface pixel_stream_to_fixed_if #(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned OUT_W         = 16,
    parameter int unsigned NUM_CH        = 1
);
    logic                            s_valid;
    logic                            s_ready;
    logic [NUM_CH*IN_DATA_WIDTH-1:0] s_data;
    logic                            m_valid;
    logic                            m_ready;
    logic [NUM_CH*OUT_W-1:0]         m_data;
    logic                            m_last;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/pixel_fx_lane.sv
// One channel of the formatter: stage1 scales the pixel, stage2 subtracts the
// centring offset and saturates to the output word.
module pixel_fx_lane
    import pixel_stream_to_fixed_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned OUT_INTEGER   = 2,
    parameter int unsigned OUT_FRACTION  = 14,
    localparam int unsigned OUT_W        = out_w(OUT_INTEGER, OUT_FRACTION)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld1_i,
    input  logic                     ld2_i,
    input  mode_e                    mode_i,
    input  mode_e                    mode1_i,
    input  logic [IN_DATA_WIDTH-1:0] pix_i,
    input  logic [OUT_W-1:0]         off1_i,
    output logic [OUT_W-1:0]         data_o,
    output logic                     sat_o
);
    localparam int unsigned     Y_W    = OUT_W + 2;
    localparam int unsigned     SH     = OUT_FRACTION - IN_DATA_WIDTH;
    localparam longint unsigned UNIT_K = unit_k(IN_DATA_WIDTH, OUT_FRACTION);

    logic [63:0]           prod;
    logic signed [Y_W-1:0] y1_d;
    logic signed [Y_W-1:0] y1_q;
    logic signed [Y_W-1:0] d2;
    logic signed [63:0]    d2_wide;
    logic signed [63:0]    clip_wide;
    logic [OUT_W-1:0]      data_d;
    logic [OUT_W-1:0]      data_q;
    logic                  sat_d;
    logic                  sat_q;

    // Stage1 next value: align the pixel to the fraction, or rescale by K in UNIT mode.
    always_comb begin
        prod = 64'(pix_i) * UNIT_K + 64'd32768;
        if (mode_i == MODE_UNIT) y1_d = Y_W'(prod >> 16);
        else                     y1_d = Y_W'(pix_i) << SH;
    end

    // Stage2 next value: optional offset subtract at Y_W bits, then clip.
    always_comb begin
        d2 = y1_q;
        if (mode1_i == MODE_CENTRE) d2 = y1_q - Y_W'($signed(off1_i));
        d2_wide   = 64'(d2);
        clip_wide = sat_clip(d2_wide, OUT_W);
        data_d    = OUT_W'(clip_wide);
        sat_d     = (clip_wide != d2_wide);
    end

    // Pipeline registers, each loaded only when its stage captures a beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            y1_q   <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (ld1_i) y1_q <= y1_d;
            if (ld2_i) begin
                data_q <= data_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign data_o = data_q;
    assign sat_o  = sat_q;
endmodule

// File: rtl/pixel_stream_to_fixed.sv
// Streaming multi-channel pixel -> signed fixed-point formatter. Holds the
// handshake, frame counter, per-frame config latch and sticky saturation flag.
module pixel_stream_to_fixed
    import pixel_stream_to_fixed_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned OUT_INTEGER   = 2,
    parameter int unsigned OUT_FRACTION  = 14,
    parameter int unsigned NUM_CH        = 1,
    parameter int unsigned FRAME_PIXELS  = 784,
    localparam int unsigned OUT_W        = out_w(OUT_INTEGER, OUT_FRACTION)
) (
    input  logic                    clk,
    input  logic                    reset,
    pixel_stream_to_fixed_if.slave  bus,
    input  logic [1:0]              cfg_mode,
    input  logic [OUT_W-1:0]        cfg_offset,
    output logic                    sat_flag
);
    localparam int unsigned CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    logic                    en;
    logic                    accept;
    logic                    first;
    logic                    at_last;
    mode_e                   mode_eff;
    logic [OUT_W-1:0]        off_eff;
    logic [CNT_W-1:0]        cnt_q;
    mode_e                   mode_lat_q;
    logic [OUT_W-1:0]        off_lat_q;
    logic                    v1_q;
    logic                    v2_q;
    logic                    last1_q;
    logic                    last2_q;
    mode_e                   mode1_q;
    logic [OUT_W-1:0]        off1_q;
    logic                    sat_q;
    logic [NUM_CH-1:0]       sat2;
    logic [NUM_CH*OUT_W-1:0] m_data_w;

    assign en          = ~v2_q | bus.m_ready;
    assign bus.s_ready = ~reset & en;
    assign accept      = bus.s_valid & bus.s_ready;
    assign first       = (cnt_q == '0);
    assign at_last     = (cnt_q == CNT_W'(FRAME_PIXELS - 1));
    // The first beat of a frame uses the live config; the rest use the latched copy.
    assign mode_eff    = first ? mode_decode(cfg_mode) : mode_lat_q;
    assign off_eff     = first ? cfg_offset : off_lat_q;

    // Frame counter, config latch, pipeline valids/sideband and sticky saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            mode_lat_q <= MODE_SHIFT;
            off_lat_q  <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            last1_q    <= 1'b0;
            last2_q    <= 1'b0;
            mode1_q    <= MODE_SHIFT;
            off1_q     <= '0;
            sat_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= at_last ? '0 : cnt_q + 1'b1;
                if (first) begin
                    mode_lat_q <= mode_eff;
                    off_lat_q  <= off_eff;
                end
            end
            if (en) begin
                v1_q <= accept;
                v2_q <= v1_q;
                if (accept) begin
                    last1_q <= at_last;
                    mode1_q <= mode_eff;
                    off1_q  <= off_eff;
                end
                if (v1_q) last2_q <= last1_q;
            end
            if (v2_q && bus.m_ready && (|sat2)) sat_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        pixel_fx_lane #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH),
            .OUT_INTEGER  (OUT_INTEGER),
            .OUT_FRACTION (OUT_FRACTION)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .ld1_i  (accept),
            .ld2_i  (en & v1_q),
            .mode_i (mode_eff),
            .mode1_i(mode1_q),
            .pix_i  (bus.s_data[g*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .off1_i (off1_q),
            .data_o (m_data_w[g*OUT_W +: OUT_W]),
            .sat_o  (sat2[g])
        );
    end

    assign bus.m_valid = v2_q;
    assign bus.m_data  = m_data_w;
    assign bus.m_last  = v2_q & last2_q;
    assign sat_flag    = sat_q;
endmodule

// File: tb/tb_pixel_stream_to_fixed.sv
// Self-checking bench for pixel_stream_to_fixed (8-bit pixels, Q2.14, one channel, 4-beat frames).
module tb_pixel_stream_to_fixed;

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        clip;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_offset = 16'h0000;
    logic        sat_flag;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        sb_q[$];
    logic [15:0] got_d[$];
    logic        got_l[$];

    int unsigned mcnt = 0;
    int          mmode = 0;
    logic [15:0] moff = 16'h0000;
    logic        sat_exp = 1'b0;
    logic        stall_prev = 1'b0;
    logic [15:0] data_prev = 16'h0000;

    pixel_stream_to_fixed_if #(.IN_DATA_WIDTH(8), .OUT_W(16), .NUM_CH(1)) bus ();

    pixel_stream_to_fixed #(
        .IN_DATA_WIDTH(8),
        .OUT_INTEGER  (2),
        .OUT_FRACTION (14),
        .NUM_CH       (1),
        .FRAME_PIXELS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cfg_mode  (cfg_mode),
        .cfg_offset(cfg_offset),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic, written from the formulas: K = round(2^30/255).
    function automatic exp_t model(input int mode, input int p, input logic [15:0] off, input logic last);
        exp_t        e;
        longint      y;
        longint      k;
        k = ((64'sd1 << 30) + 127) / 255;
        case (mode)
            1:       y = (p * k + 32768) >>> 16;
            2:       y = longint'(p * 64) - longint'($signed(off));
            default: y = p * 64;
        endcase
        e.clip = 1'b0;
        if (y > 32767)  begin y = 32767;  e.clip = 1'b1; end
        if (y < -32768) begin y = -32768; e.clip = 1'b1; end
        e.data = 16'(y);
        e.last = last;
        return e;
    endfunction

    // Monitor: push expectations on input accept, pop and compare on output accept.
    always @(negedge clk) begin
        exp_t e;
        int   md;
        logic [15:0] off;
        if (reset) begin
            sb_q.delete();
            mcnt       = 0;
            mmode      = 0;
            moff       = 16'h0000;
            sat_exp    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            check("sat_flag", 32'(sat_flag), 32'(sat_exp));
            if (stall_prev) begin
                check("stall_valid", 32'(bus.m_valid), 32'd1);
                check("stall_data", 32'(bus.m_data), 32'(data_prev));
            end
            if (bus.m_valid && !bus.m_ready) check("stall_s_ready", 32'(bus.s_ready), 32'd0);
            stall_prev = bus.m_valid && !bus.m_ready;
            data_prev  = bus.m_data;
            if (bus.s_valid && bus.s_ready) begin
                if (mcnt == 0) begin
                    mmode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
                    moff  = cfg_offset;
                end
                md  = mmode;
                off = moff;
                sb_q.push_back(model(md, int'(bus.s_data), off, mcnt == 3));
                mcnt = (mcnt == 3) ? 0 : mcnt + 1;
            end
            if (bus.m_valid && bus.m_ready) begin
                got_d.push_back(bus.m_data);
                got_l.push_back(bus.m_last);
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'(bus.m_data), 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    check("m_data", 32'(bus.m_data), 32'(e.data));
                    check("m_last", 32'(bus.m_last), 32'(e.last));
                    if (e.clip) sat_exp = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    // Present one beat and return at posedge+1 right after it is accepted.
    task automatic send(input logic [7:0] p);
        int unsigned n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = p;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        bus.s_valid = 1'b0;
        while ((sb_q.size() != 0 || bus.m_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b1;

        // 1: SHIFT, latency and two values
        cfg_mode = 2'd0;
        do_reset();
        clear_log();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h80;
        @(negedge clk);
        check("t1_accept", 32'(bus.s_ready), 32'd1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("t1_lat1_m_valid", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        check("t1_lat2_m_valid", 32'(bus.m_valid), 32'd1);
        @(posedge clk); #1;
        send(8'hFF);
        drain();
        check("t1_count", 32'(got_d.size()), 32'd2);
        if (got_d.size() == 2) begin
            check("t1_p80", 32'(got_d[0]), 32'h2000);
            check("t1_pFF", 32'(got_d[1]), 32'h3FC0);
        end

        // 2: UNIT (128/255 * 2^14 = 8224.125, rounds to 0x2020)
        cfg_mode = 2'd1;
        do_reset();
        clear_log();
        send(8'd255);
        send(8'd0);
        send(8'd128);
        drain();
        check("t2_count", 32'(got_d.size()), 32'd3);
        if (got_d.size() == 3) begin
            check("t2_p255", 32'(got_d[0]), 32'h4000);
            check("t2_p0", 32'(got_d[1]), 32'h0000);
            check("t2_p128", 32'(got_d[2]), 32'h2020);
        end

        // 3: CENTRE, negative result then positive clip in the next frame
        cfg_mode   = 2'd2;
        cfg_offset = 16'h2000;
        do_reset();
        clear_log();
        send(8'h00);
        send(8'h10);
        send(8'h20);
        send(8'h30);
        drain();
        check("t3_no_sat", 32'(sat_flag), 32'd0);
        cfg_offset = 16'h8000;
        send(8'hFF);
        drain();
        check("t3_count", 32'(got_d.size()), 32'd5);
        if (got_d.size() == 5) begin
            check("t3_p0", 32'(got_d[0]), 32'hE000);
            check("t3_clip", 32'(got_d[4]), 32'h7FFF);
        end
        check("t3_sat", 32'(sat_flag), 32'd1);

        // 6: reset with two beats in flight, then a clean frame
        send(8'h11);
        send(8'h22);
        do_reset();
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        clear_log();
        cfg_mode = 2'd0;
        for (int i = 0; i < 4; i++) send(8'(i + 1));
        drain();
        check("t6_count", 32'(got_d.size()), 32'd4);
        if (got_d.size() == 4) begin
            check("t6_last3", 32'(got_l[3]), 32'd1);
            check("t6_last2", 32'(got_l[2]), 32'd0);
            check("t6_data0", 32'(got_d[0]), 32'h0040);
        end

        // 4: backpressure for 5 cycles while the source keeps pushing
        cfg_mode = 2'd0;
        do_reset();
        clear_log();
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(i * 16 + 1));
                bus.s_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                bus.m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();
        check("t4_count", 32'(got_d.size()), 32'd8);
        if (got_d.size() == 8) begin
            for (int i = 0; i < 8; i++) check("t4_order", 32'(got_d[i]), 32'((i * 16 + 1) * 64));
        end

        // 5: 4-beat frames, mode change mid-frame applies from the next frame
        cfg_mode = 2'd0;
        do_reset();
        clear_log();
        send(8'hFF);
        cfg_mode = 2'd1;
        for (int i = 1; i < 9; i++) send(8'hFF);
        drain();
        check("t5_count", 32'(got_d.size()), 32'd9);
        if (got_d.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                check("t5_last", 32'(got_l[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
                check("t5_mode", 32'(got_d[i]), (i < 4) ? 32'h3FC0 : 32'h4000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
